jt12_bus_master: RTL and testbench

//  Bus initiator for the jt12 CPU port: accepts queued register writes (part, reg, value)
//  and drives the cs_n/wr_n/addr/din cycles the YM2612 expects, polling the busy flag
//  (dout[7]) before each write. Sits between a sound driver/test sequencer and jt12,

---
 rtl/jt12_bus_master.sv | 207 ++++++++++++++++++++
 tb/tb_jt12_bus_master.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_bus_master.sv
// rtl/jt12_bus_master.sv - queued register-write bus initiator for the jt12 CPU port
module jt12_bus_master #(
    parameter int DEPTH    = 16,
    parameter int WR_PULSE = 2,
    parameter int RD_WAIT  = 1,
    parameter int BUSY_TO  = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cen,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_part,
    input  logic [7:0]                 cmd_reg,
    input  logic [7:0]                 cmd_val,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       idle,
    output logic                       busy_tout,
    input  logic                       tout_clr,
    output logic [7:0]                 ym_din,
    output logic [1:0]                 ym_addr,
    output logic                       ym_cs_n,
    output logic                       ym_wr_n,
    input  logic [7:0]                 ym_dout
);
    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [7:0]    RD_LAST    = 8'(RD_WAIT - 1);
    localparam logic [7:0]    PULSE_LAST = 8'(WR_PULSE - 1);
    localparam logic [7:0]    TO_LAST    = 8'(BUSY_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_POLL, S_GAP0, S_ADDR, S_GAP1, S_DATA, S_GAP2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    bcnt_q, bcnt_d;
    logic          tout_q, tout_d;
    logic          cs_n_q, cs_n_d;
    logic          wr_n_q, wr_n_d;
    logic [1:0]    addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [16:0]   mem_q [DEPTH];

    logic          push, pop, tout_set;
    logic [16:0]   head;
    logic          unused_dout;

    assign cmd_ready   = (level_q != LVL_FULL);
    assign push        = cmd_valid && cmd_ready;
    assign head        = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign idle        = (state_q == S_IDLE) && (level_q == '0);
    assign busy_tout   = tout_q;
    assign ym_din      = din_q;
    assign ym_addr     = addr_q;
    assign ym_cs_n     = cs_n_q;
    assign ym_wr_n     = wr_n_q;
    assign unused_dout = ^ym_dout[6:0];

    // Bus sequencer: next state and next registered bus outputs, cen-gated
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        cs_n_d   = cs_n_q;
        wr_n_d   = wr_n_q;
        addr_d   = addr_q;
        din_d    = din_q;
        pop      = 1'b0;
        tout_set = 1'b0;
        if (cen) begin
            case (state_q)
                S_IDLE: if (level_q != '0) begin
                    state_d = S_POLL;
                    cnt_d   = '0;
                    bcnt_d  = '0;
                    cs_n_d  = 1'b0;
                    wr_n_d  = 1'b1;
                    addr_d  = 2'd0;
                end
                S_POLL: begin
                    if (cnt_q != RD_LAST) begin
                        cnt_d = cnt_q + 8'd1;
                    end else if (!ym_dout[7]) begin
                        state_d = S_GAP0;
                        cs_n_d  = 1'b1;
                    end else if (bcnt_q == TO_LAST) begin
                        // chip never reported ready: write anyway and flag it
                        tout_set = 1'b1;
                        state_d  = S_GAP0;
                        cs_n_d   = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + 8'd1;
                    end
                end
                S_GAP0: begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                    addr_d  = {head[16], 1'b0};
                    din_d   = head[15:8];
                    cs_n_d  = 1'b0;
                    wr_n_d  = 1'b0;
                end
                S_ADDR: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d = S_GAP1;
                        cs_n_d  = 1'b1;
                        wr_n_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_GAP1: begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    addr_d  = {head[16], 1'b1};
                    din_d   = head[7:0];
                    cs_n_d  = 1'b0;
                    wr_n_d  = 1'b0;
                end
                S_DATA: begin
                    if (cnt_q == PULSE_LAST) begin
                        state_d = S_GAP2;
                        cs_n_d  = 1'b1;
                        wr_n_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_GAP2: begin
                    // head is retired only here, so its data is stable for the whole command
                    pop = 1'b1;
                    if (level_q > LVL_ONE) begin
                        state_d = S_POLL;
                        cnt_d   = '0;
                        bcnt_d  = '0;
                        cs_n_d  = 1'b0;
                        wr_n_d  = 1'b1;
                        addr_d  = 2'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cs_n_d  = 1'b1;
                    wr_n_d  = 1'b1;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and sticky timeout flag
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        tout_d = tout_set ? 1'b1 : (tout_clr ? 1'b0 : tout_q);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            tout_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            addr_q   <= 2'd0;
            din_q    <= 8'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            tout_q   <= tout_d;
            cs_n_q   <= cs_n_d;
            wr_n_q   <= wr_n_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Command storage; entries are {part, reg, val}
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_part, cmd_reg, cmd_val};
        end
    end
endmodule

// File: tb/tb_jt12_bus_master.sv
// tb/tb_jt12_bus_master.sv - self-checking bench for jt12_bus_master
module tb_jt12_bus_master;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_part = 1'b0;
    logic [7:0] cmd_reg = 8'd0;
    logic [7:0] cmd_val = 8'd0;
    logic [4:0] level;
    logic       idle;
    logic       busy_tout;
    logic       tout_clr = 1'b0;
    logic [7:0] ym_din;
    logic [1:0] ym_addr;
    logic       ym_cs_n;
    logic       ym_wr_n;
    logic [7:0] ym_dout;

    int checks = 0;
    int errors = 0;

    jt12_bus_master dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_part(cmd_part), .cmd_reg(cmd_reg), .cmd_val(cmd_val),
        .level(level), .idle(idle), .busy_tout(busy_tout), .tout_clr(tout_clr),
        .ym_din(ym_din), .ym_addr(ym_addr), .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n),
        .ym_dout(ym_dout)
    );

    always #5 clk = ~clk;

    // cen: every clock, or one clock in three
    logic cen_div = 1'b0;
    int   cen_ph = 0;
    always @(negedge clk) begin
        if (cen_div) begin
            cen_ph = (cen_ph == 2) ? 0 : cen_ph + 1;
            cen = (cen_ph == 0);
        end else begin
            cen = 1'b1;
        end
    end

    // jt12 responder: busy flag per mode, write-phase log and register file model
    int         busy_mode = 0;
    logic       poll_clear = 1'b0;
    int         poll_samples = 0;
    logic [9:0] wr_log [256];
    int         wr_cnt = 0;
    logic       in_wr = 1'b0;
    int         cur_len = 0;
    int         bad_len = 0;
    logic [8:0] model_sel = 9'd0;
    logic [7:0] model_regs [512];

    assign ym_dout = {(busy_mode == 2) ? 1'b1 :
                      (busy_mode == 1) ? (poll_samples < 10) : 1'b0, 7'd0};

    always @(posedge clk) begin
        if (poll_clear) poll_samples <= 0;
        else if (rst_n && cen && !ym_cs_n && ym_wr_n) poll_samples <= poll_samples + 1;
        if (!rst_n) begin
            in_wr <= 1'b0;
        end else if (cen) begin
            if (!ym_cs_n && !ym_wr_n) begin
                if (!in_wr) begin
                    wr_log[wr_cnt[7:0]] <= {ym_addr, ym_din};
                    wr_cnt <= wr_cnt + 1;
                    if (!ym_addr[0]) model_sel <= {ym_addr[1], ym_din};
                    else model_regs[model_sel] <= ym_din;
                    cur_len <= 1;
                    in_wr <= 1'b1;
                end else begin
                    cur_len <= cur_len + 1;
                end
            end else if (in_wr) begin
                in_wr <= 1'b0;
                if (cur_len != 2) bad_len <= bad_len + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic p, input logic [7:0] r, input logic [7:0] v);
        cmd_part = p; cmd_reg = r; cmd_val = v; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!idle && n < bound);
        if (!idle) check("idle_timeout", 32'(idle), 32'd1);
    endtask

    task automatic clear_polls();
        poll_clear = 1'b1;
        @(posedge clk); #1;
        poll_clear = 1'b0;
    endtask

    typedef struct {
        logic       part;
        logic [7:0] rg;
        logic [7:0] val;
        logic [1:0] a0;
        logic [1:0] a1;
    } vec_t;
    vec_t tbl [5];

    initial begin
        int n;
        int base;
        tbl[0] = '{1'b0, 8'h28, 8'hF0, 2'd0, 2'd1};
        tbl[1] = '{1'b1, 8'hB4, 8'hC0, 2'd2, 2'd3};
        tbl[2] = '{1'b0, 8'h00, 8'h00, 2'd0, 2'd1};
        tbl[3] = '{1'b1, 8'hFF, 8'hFF, 2'd2, 2'd3};
        tbl[4] = '{1'b0, 8'h30, 8'h71, 2'd0, 2'd1};
        for (int i = 0; i < 512; i++) model_regs[i] = 8'h00;

        // power-on reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", 32'(ym_cs_n), 32'd1);
        check("rst_wr_n", 32'(ym_wr_n), 32'd1);
        check("rst_addr", 32'(ym_addr), 32'd0);
        check("rst_din", 32'(ym_din), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_tout", 32'(busy_tout), 32'd0);
        rst_n = 1'b1;

        // reset in the middle of the address phase
        push(1'b0, 8'h22, 8'h08);
        repeat (3) @(posedge clk);
        #1;
        check("mid_addr_wr_n", 32'(ym_wr_n), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_cs_n", 32'(ym_cs_n), 32'd1);
        check("abort_wr_n", 32'(ym_wr_n), 32'd1);
        check("abort_level", 32'(level), 32'd0);
        check("abort_idle", 32'(idle), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single unbusy writes from the vector table
        for (int i = 0; i < 5; i++) begin
            base = wr_cnt;
            push(tbl[i].part, tbl[i].rg, tbl[i].val);
            wait_idle(50, n);
            check($sformatf("v%0d_clocks", i), 32'(n), 32'd9);
            check($sformatf("v%0d_nwr", i), 32'(wr_cnt - base), 32'd2);
            check($sformatf("v%0d_addr_ph", i), 32'(wr_log[base]), 32'({tbl[i].a0, tbl[i].rg}));
            check($sformatf("v%0d_data_ph", i), 32'(wr_log[base + 1]), 32'({tbl[i].a1, tbl[i].val}));
            check($sformatf("v%0d_model", i), 32'(model_regs[{tbl[i].part, tbl[i].rg}]), 32'(tbl[i].val));
        end

        // busy for 10 polls, then ready
        clear_polls();
        busy_mode = 1;
        base = wr_cnt;
        push(1'b1, 8'h44, 8'h5A);
        wait_idle(200, n);
        check("busy10_polls", 32'(poll_samples), 32'd11);
        check("busy10_nwr", 32'(wr_cnt - base), 32'd2);
        check("busy10_data", 32'(wr_log[base + 1]), 32'h35A);
        check("busy10_tout", 32'(busy_tout), 32'd0);

        // busy stuck high: forced write after the timeout
        clear_polls();
        busy_mode = 2;
        base = wr_cnt;
        push(1'b0, 8'h2B, 8'h80);
        wait_idle(400, n);
        busy_mode = 0;
        check("stuck_polls", 32'(poll_samples), 32'd255);
        check("stuck_nwr", 32'(wr_cnt - base), 32'd2);
        check("stuck_addr", 32'(wr_log[base]), 32'h02B);
        check("stuck_tout", 32'(busy_tout), 32'd1);
        tout_clr = 1'b1;
        @(posedge clk); #1;
        tout_clr = 1'b0;
        check("tout_cleared", 32'(busy_tout), 32'd0);

        // fill the FIFO with cen at 1/3 duty
        cen_div = 1'b1;
        base = wr_cnt;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fill%0d_ready", i), 32'(cmd_ready), 32'd1);
            push(i[0], 8'h40 + 8'(i), 8'hA0 ^ 8'(i));
        end
        check("full_level", 32'(level), 32'd16);
        check("full_ready", 32'(cmd_ready), 32'd0);
        cmd_part = 1'b1; cmd_reg = 8'hEE; cmd_val = 8'hEE; cmd_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("full_ignored", 32'(level), 32'd16);
        wait_idle(2000, n);
        check("fill_nwr", 32'(wr_cnt - base), 32'd32);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fill%0d_addr", i), 32'(wr_log[base + 2*i]),
                  32'({i[0], 1'b0, 8'h40 + 8'(i)}));
            check($sformatf("fill%0d_data", i), 32'(wr_log[base + 2*i + 1]),
                  32'({i[0], 1'b1, 8'hA0 ^ 8'(i)}));
        end
        cen_div = 1'b0;

        check("pulse_len", 32'(bad_len), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
